inv_key_schedule: RTL and testbench

//   Iterative AES-128 decryption key scheduler. Takes the cipher key and runs the

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/inv_key_step.sv | 52 +++++
 rtl/inv_key_schedule.sv | 139 +++++++++++++
 tb/tb_inv_key_schedule.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 definitions for the key schedule blocks.
//   Contents:
//     BYTE / DWORD / LENGTH / NROUNDS  datapath widths and round count
//     state_t                          scheduler FSM encoding (IDLE/EXPAND/EMIT)
//     SBOX_TABLE, sbox()               forward AES S-box
//     sub_word(), rot_word(), rcon()   word helpers used by the key expansion
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int BYTE    = 8;
    localparam int DWORD   = 32;
    localparam int LENGTH  = 128;
    localparam int NROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the top byte and entry 0xff in the bottom
    // byte, so one row of the usual 16x16 table maps to one 128-bit chunk.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives at bit offset (255-b)*8; 255-b is simply ~b for a byte.
    function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_TABLE[idx +: BYTE];
    endfunction

    function automatic logic [DWORD-1:0] sub_word(input logic [DWORD-1:0] w);
        logic [DWORD-1:0] res;
        res = '0;
        for (int i = 0; i < DWORD / BYTE; i++) begin
            res[i*BYTE +: BYTE] = sbox(w[i*BYTE +: BYTE]);
        end
        return res;
    endfunction

    function automatic logic [DWORD-1:0] rot_word(input logic [DWORD-1:0] w);
        return {w[DWORD-BYTE-1:0], w[DWORD-1:DWORD-BYTE]};
    endfunction

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [DWORD-1:0] rcon(input logic [3:0] r);
        logic [BYTE-1:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, {(DWORD-BYTE){1'b0}}};
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// ---------------------------------------------------------------------------
// inv_key_step
//   One combinational step of the AES-128 key schedule, in either direction.
//   Both directions share a single SubWord path; only its source word and the
//   recombination of the output words differ.
//   Ports:
//     key       in   128  current round key, w0 in [127:96], w3 in [31:0]
//     r         in   4    round number used for Rcon (1..10)
//     dir       in   1    0 = forward step (key r-1 -> r), 1 = inverse (r -> r-1)
//     next_key  out  128  resulting round key
// ---------------------------------------------------------------------------
module inv_key_step
    import aes_pkg::*;
(
    input  logic [LENGTH-1:0] key,
    input  logic [3:0]        r,
    input  logic              dir,
    output logic [LENGTH-1:0] next_key
);

    logic [DWORD-1:0] k0, k1, k2, k3;
    logic [DWORD-1:0] sub_src;
    logic [DWORD-1:0] t;
    logic [DWORD-1:0] n0, n1, n2, n3;

    assign k0 = key[127:96];
    assign k1 = key[95:64];
    assign k2 = key[63:32];
    assign k3 = key[31:0];

    // Going backwards, the previous key's w3 is recovered as k3^k2, and that
    // recovered word is what originally fed RotWord/SubWord.
    assign sub_src = dir ? (k3 ^ k2) : k3;
    assign t       = sub_word(rot_word(sub_src)) ^ rcon(r);

    // Forward chains the XORs left to right; inverse undoes each link pairwise.
    always_comb begin
        n0 = k0 ^ t;
        n1 = n0 ^ k1;
        n2 = n1 ^ k2;
        n3 = n2 ^ k3;
        if (dir) begin
            n0 = k0 ^ t;
            n1 = k1 ^ k0;
            n2 = k2 ^ k1;
            n3 = k3 ^ k2;
        end
    end

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
//   Iterative AES-128 decryption key scheduler. Loads the cipher key, walks
//   the forward schedule up to round key 10, then walks it backwards and
//   streams round keys 10..0 over a valid/ready interface.
//   Ports:
//     clk         in   1    clock, rising edge
//     rst         in   1    synchronous active-high reset
//     start       in   1    latch cipher_key and begin (IDLE only)
//     cipher_key  in   128  round key 0
//     busy        out  1    high while expanding or emitting
//     key_valid   out  1    key_out/key_round valid
//     key_ready   in   1    consumer accepts on key_valid && key_ready
//     key_out     out  128  current round key (0 when not valid)
//     key_round   out  4    round index of key_out (0 when not valid)
//     done        out  1    one-cycle pulse after round key 0 is accepted
// ---------------------------------------------------------------------------
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] cipher_key,
    output logic              busy,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [LENGTH-1:0] key_out,
    output logic [3:0]        key_round,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [LENGTH-1:0] key_reg;
    logic [LENGTH-1:0] step_key;
    logic [3:0]        rnd;
    logic [3:0]        step_rnd;
    logic              step_dir;
    logic              handshake;
    logic              last_key;
    logic              done_reg;

    assign handshake = (state == EMIT) && key_ready;
    assign last_key  = handshake && (rnd == 4'd0);

    // The step block is reused in both phases: while expanding it produces
    // key rnd+1, while emitting it recovers key rnd-1 from key rnd.
    assign step_dir = (state == EMIT);
    assign step_rnd = step_dir ? rnd : rnd + 4'd1;

    inv_key_step u_step (
        .key      (key_reg),
        .r        (step_rnd),
        .dir      (step_dir),
        .next_key (step_key)
    );

    // State register; reset drops straight back to IDLE from any phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Expansion ends on the cycle that writes round 10;
    // emission ends once the consumer takes round key 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (rnd == 4'(NROUNDS - 1)) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (last_key) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Key register, round counter and done pulse. In EMIT the key only moves
    // on a handshake, so an unaccepted key stays on the output unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg  <= '0;
            rnd      <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= last_key;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= cipher_key;
                        rnd     <= '0;
                    end
                end
                EXPAND: begin
                    key_reg <= step_key;
                    rnd     <= rnd + 4'd1;
                end
                EMIT: begin
                    if (handshake && (rnd != 4'd0)) begin
                        key_reg <= step_key;
                        rnd     <= rnd - 4'd1;
                    end
                end
                default: begin
                    key_reg <= key_reg;
                    rnd     <= rnd;
                end
            endcase
        end
    end

    // Outputs are gated so nothing leaks onto the key bus outside EMIT.
    always_comb begin
        busy      = (state != IDLE);
        key_valid = (state == EMIT);
        key_out   = '0;
        key_round = '0;
        if (state == EMIT) begin
            key_out   = key_reg;
            key_round = rnd;
        end
        done = done_reg;
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_inv_key_schedule
//   Scoreboard bench for inv_key_schedule. Stimulus pushes the expected key
//   sequence for each run into a queue; a monitor pops and compares on every
//   accepted key, checks stall stability, idle zeroing and the done pulse.
//   The reference schedule uses an S-box derived from GF(2^8) arithmetic.
// ---------------------------------------------------------------------------
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready = 1'b1;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         done;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    int stall_round = -1;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] OTHER    = 128'h000102030405060708090a0b0c0d0e0f;

    inv_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .key_round  (key_round),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, rot, t;
        logic [7:0]  rc;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = xtime(rc);
        rot = {w3[23:0], w3[31:24]};
        t = {sbox_ref(rot[31:24]), sbox_ref(rot[23:16]),
             sbox_ref(rot[15:8]), sbox_ref(rot[7:0])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- helpers ----------------
    task automatic check_output(input string name, input logic [127:0] got,
                                input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected keys for one run, highest round first, down to min_round.
    // Hand-computed vectors replace the model where they are known.
    task automatic push_schedule(input logic [127:0] k, input int min_round,
                                 input bit use_h10, input logic [127:0] h10,
                                 input bit use_h1, input logic [127:0] h1);
        logic [127:0] rk[11];
        rk[0] = k;
        for (int r = 1; r <= 10; r++) rk[r] = model_fwd(rk[r-1], r);
        if (use_h10) rk[10] = h10;
        if (use_h1)  rk[1]  = h1;
        for (int r = 10; r >= min_round; r--) begin
            sb_q.push_back('{key: rk[r], round: 4'(r)});
        end
    endtask

    task automatic apply_stimulus(input logic [127:0] k);
        @(negedge clk);
        cipher_key = k;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < max_cycles);
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s: got no done within %0d cycles expected done", name, max_cycles);
        end
    endtask

    task automatic wait_round(input string name, input int r, input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(key_valid && int'(key_round) == r) && n < max_cycles);
        checks++;
        if (!(key_valid && int'(key_round) == r)) begin
            errors++;
            $display("[TB] FAIL %s: got round %0d valid %b expected round %0d valid 1",
                     name, key_round, key_valid, r);
        end
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (key_valid && int'(key_round) == stall_round) key_ready = 1'b0;
            else if (ready_mode == 1) key_ready = 1'($urandom_range(0, 1));
            else key_ready = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic         stalled;
        logic [127:0] stall_key;
        logic [3:0]   stall_rnd;
        logic         done_exp;
        logic         done_exp_next;
        exp_t         e;
        stalled  = 1'b0;
        done_exp = 1'b0;
        stall_key = '0;
        stall_rnd = '0;
        forever begin
            @(negedge clk);
            done_exp_next = 1'b0;
            if (done || done_exp) check_output("done_pulse", 128'(done), 128'(done_exp));
            if (stalled && !rst) begin
                check_output("stall_hold", {key_valid, key_round, key_out},
                             {1'b1, stall_rnd, stall_key});
            end
            stalled = 1'b0;
            if (key_valid) begin
                if (key_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_key: got round %0d key %h expected no key",
                                 key_round, key_out);
                    end else begin
                        e = sb_q.pop_front();
                        check_output("key_round", 128'(key_round), 128'(e.round));
                        check_output("key_out", key_out, e.key);
                        if (e.round == 4'd0) done_exp_next = 1'b1;
                    end
                end else begin
                    stalled   = 1'b1;
                    stall_key = key_out;
                    stall_rnd = key_round;
                end
            end else begin
                check_output("idle_zero", {key_round, key_out}, 132'd0);
            end
            done_exp = done_exp_next;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cipher_key = '0;
        repeat (3) @(negedge clk);
        check_output("reset_outputs", {busy, key_valid, done, key_round, key_out}, 0);
        rst = 1'b0;

        $display("[TB] test 1: FIPS-197 key, ready high");
        ready_mode = 0;
        push_schedule(FIPS_KEY, 0, 1'b1, FIPS_R10, 1'b1, FIPS_R1);
        apply_stimulus(FIPS_KEY);
        check_output("busy_expand", 128'(busy), 128'd1);
        wait_done("t1_done", 60);
        check_output("t1_drained", 128'(sb_q.size()), 128'd0);

        $display("[TB] test 2: backpressure");
        ready_mode = 1;
        push_schedule(FIPS_KEY, 0, 1'b1, FIPS_R10, 1'b1, FIPS_R1);
        apply_stimulus(FIPS_KEY);
        wait_done("t2_done", 400);
        check_output("t2_drained", 128'(sb_q.size()), 128'd0);

        $display("[TB] test 3: start while busy");
        ready_mode = 0;
        push_schedule(FIPS_KEY, 0, 1'b1, FIPS_R10, 1'b1, FIPS_R1);
        apply_stimulus(FIPS_KEY);
        repeat (3) @(negedge clk);
        cipher_key = OTHER;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_round("t3_round6", 6, 60);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done("t3_done", 60);
        check_output("t3_drained", 128'(sb_q.size()), 128'd0);

        $display("[TB] test 4: reset during emit");
        stall_round = 5;
        push_schedule(FIPS_KEY, 6, 1'b1, FIPS_R10, 1'b0, '0);
        apply_stimulus(FIPS_KEY);
        wait_round("t4_round5", 5, 60);
        rst = 1'b1;
        @(negedge clk);
        check_output("t4_abort", {busy, key_valid, done, key_round, key_out}, 0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        stall_round = -1;
        check_output("t4_drained", 128'(sb_q.size()), 128'd0);
        push_schedule(FIPS_KEY, 0, 1'b1, FIPS_R10, 1'b1, FIPS_R1);
        apply_stimulus(FIPS_KEY);
        wait_done("t4_done", 60);

        $display("[TB] test 5: start on done cycle");
        push_schedule(128'd0, 0, 1'b1, ZERO_R10, 1'b0, '0);
        cipher_key = '0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done("t5_done", 60);
        check_output("t5_drained", 128'(sb_q.size()), 128'd0);

        $display("[TB] test 6: random keys");
        ready_mode = 1;
        for (int i = 0; i < 3; i++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            push_schedule(k, 0, 1'b0, '0, 1'b0, '0);
            apply_stimulus(k);
            wait_done("t6_done", 400);
        end

        repeat (3) @(negedge clk);
        check_output("final_drained", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
